pdm_mic_rx: RTL and testbench

Receive path for the audio subsystem. The block drives the clock of an on-board PDM microphone, samples the 1-bit PDM stream, decimates it with a 2nd-order CIC filter, and emits 8-bit samples with a one-cycle valid strobe. Samples are in the same unsigned 8-bit format the PWM audio output consumes, so mic-to-speaker loopback needs no conversion. It sits next to the NCO/PWM output path in the top level and runs on the 100 MHz board clock.

---
 rtl/pdm_mic_rx_if.sv | 12 +
 rtl/pdm_mic_rx.sv | 107 ++++++++++
 tb/tb_pdm_mic_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pdm_mic_rx_if.sv
// pdm_mic_rx_if: microphone pins and decimated sample stream of pdm_mic_rx
interface pdm_mic_rx_if;
    logic       enable;
    logic       M_CLK;
    logic       M_DATA;
    logic       M_LRSEL;
    logic [7:0] value;
    logic       valid;
    logic       running;
    modport master (input enable, M_DATA, output M_CLK, M_LRSEL, value, valid, running);
    modport slave  (output enable, M_DATA, input M_CLK, M_LRSEL, value, valid, running);
endinterface

// File: rtl/pdm_mic_rx.sv
// pdm_mic_rx: PDM mic clock + 2nd-order CIC decimator to 8-bit samples; `define PDM_RX_SIGNED_EN for signed output
module pdm_mic_rx #(
    parameter int CLK_DIV    = 50,
    parameter int DECIM_LOG2 = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    pdm_mic_rx_if.master bus
);
    localparam int W  = 2 * DECIM_LOG2 + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [W-1:0]  SAT_MAX  = {1'b0, {(W-1){1'b1}}};
`ifdef PDM_RX_SIGNED_EN
    localparam logic [7:0] VALUE_RST = 8'h00;
`else
    localparam logic [7:0] VALUE_RST = 8'h80;
`endif
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
    state_t state, state_nxt;
    logic [1:0]            sync;
    logic [DW-1:0]         div_cnt;
    logic                  m_clk;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic                  settle_cnt;
    logic [W-1:0]          i1, i2, i2_d, c1_d, i1_nxt, i2_nxt, c1, c2;
    logic [7:0]            usat, sample, sample_nxt;
    logic                  valid_q, cap, dec_done;
    // A bit is captured on the M_CLK falling edge; the R-th capture closes a decimation window
    assign cap      = state != IDLE && div_cnt == DIV_LAST && m_clk;
    assign dec_done = cap && &dec_cnt;
    assign i1_nxt   = i1 + W'(sync[1]);
    assign i2_nxt   = i2 + i1_nxt;
    assign c1       = i2_nxt - i2_d;
    assign c2       = c1 - c1_d;
    assign usat     = c2 > SAT_MAX ? 8'hFF : c2[W-2 -: 8];
`ifdef PDM_RX_SIGNED_EN
    assign sample_nxt = {~usat[7], usat[6:0]};
`else
    assign sample_nxt = usat;
`endif
    // Two-flop synchronizer for the asynchronous PDM data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], bus.M_DATA};
    end
    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end
    // Next state: disable always wins; SETTLE ends after its second decimation result
    always_comb begin
        state_nxt = !bus.enable ? IDLE :
                    state == IDLE ? SETTLE :
                    (state == SETTLE && dec_done && settle_cnt) ? RUN : state;
    end
    // Outputs driven from state and datapath registers
    always_comb begin
        bus.M_CLK   = m_clk;
        bus.M_LRSEL = 1'b0;
        bus.running = state == RUN;
        bus.value   = sample;
        bus.valid   = valid_q;
    end
    // Divider, CIC integrators/combs and output sample; filter state clears on the way to IDLE, sample holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            m_clk      <= 1'b0;
            dec_cnt    <= '0;
            settle_cnt <= 1'b0;
            i1         <= '0;
            i2         <= '0;
            i2_d       <= '0;
            c1_d       <= '0;
            sample     <= VALUE_RST;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= dec_done && state == RUN && state_nxt == RUN;
            if (dec_done && state == RUN && state_nxt == RUN) sample <= sample_nxt;
            if (state_nxt == IDLE) begin
                div_cnt    <= '0;
                m_clk      <= 1'b0;
                dec_cnt    <= '0;
                settle_cnt <= 1'b0;
                i1         <= '0;
                i2         <= '0;
                i2_d       <= '0;
                c1_d       <= '0;
            end else if (state != IDLE) begin
                div_cnt <= div_cnt == DIV_LAST ? '0 : div_cnt + DW'(1);
                if (div_cnt == DIV_LAST) m_clk <= ~m_clk;
                if (cap) begin
                    i1      <= i1_nxt;
                    i2      <= i2_nxt;
                    dec_cnt <= dec_cnt + DECIM_LOG2'(1);
                end
                if (dec_done) begin
                    i2_d       <= i2_nxt;
                    c1_d       <= c1;
                    settle_cnt <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_mic_rx.sv
// tb_pdm_mic_rx: directed phases of PDM patterns against a triangular-kernel CIC reference
module tb_pdm_mic_rx;
    localparam int CD = 3;
    localparam int DL = 4;
    localparam int R  = 1 << DL;
    localparam int W  = 2 * DL + 1;
    localparam int WC = 2 * CD * R;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    pdm_mic_rx_if bus();
    pdm_mic_rx #(.CLK_DIV(CD), .DECIM_LOG2(DL)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    int passed = 0;
    int total = 0;
    int fails = 0;
    int e = 0;
    int mode = 0;
    bit active = 1'b0;
    bit q[$];
    logic [7:0] exp_val = 8'h80;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask
    function automatic int ramp(int a);
        return a > 0 ? a : 0;
    endfunction
    // Output k of a 2nd-order CIC is the input convolved with a triangle spanning the last 2R bits
    function automatic logic [7:0] model(int k);
        longint c2 = 0;
        for (int m = 1; m <= k * R; m++)
            if (q[m-1]) c2 += ramp(k*R - m + 1) - 2 * ramp((k-1)*R - m + 1) + ramp((k-2)*R - m + 1);
        if (c2 > (1 << (W-1)) - 1) c2 = (1 << (W-1)) - 1;
        return 8'(c2 >> (W - 9));
    endfunction
    function automatic bit next_bit(int j);
        case (mode)
            0:       return 1'($urandom_range(1, 0));
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return j % 2 == 0;
            default: return j % 4 != 3;
        endcase
    endfunction
    task automatic step();
        logic ev;
        bit b;
        @(posedge clk);
        if (active) e++;
        @(negedge clk);
        ev = active && e > 0 && e % WC == 0 && e / WC >= 3;
        if (ev) exp_val = model(e / WC);
        chk("valid", bus.valid, ev);
        chk("value", bus.value, exp_val);
        chk("m_clk", bus.M_CLK, active ? (e / CD) % 2 : 0);
        chk("running", bus.running, active && e >= 2 * WC);
        chk("lrsel", bus.M_LRSEL, 0);
        if (active && e % (2 * CD) == CD) begin
            b = next_bit(q.size());
            bus.M_DATA = b;
            q.push_back(b);
        end
    endtask
    task automatic start(input int md);
        mode = md;
        q.delete();
        e = -1;
        active = 1'b1;
        bus.enable = 1'b1;
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.M_DATA = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_value", bus.value, 8'h80);
        chk("rst_valid", bus.valid, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_mclk", bus.M_CLK, 0);
        chk("rst_lrsel", bus.M_LRSEL, 0);
        reset_n = 1'b1;
        repeat (10) step();
        start(1);
        repeat (6 * WC) step();
        chk("ones_ff", bus.value, 8'hFF);
        mode = 2;
        repeat (3 * WC) step();
        chk("zeros_00", bus.value, 8'h00);
        mode = 3;
        repeat (3 * WC) step();
        chk("alt_80", bus.value, 8'h80);
        mode = 4;
        repeat (3 * WC) step();
        chk("three_qtr_c0", bus.value, 8'hC0);
        mode = 1;
        repeat (3 * WC) step();
        chk("back_to_ones_ff", bus.value, 8'hFF);
        mode = 0;
        repeat (4 * WC + 17) step();
        bus.enable = 1'b0;
        active = 1'b0;
        repeat (100) step();
        start(1);
        repeat (4 * WC) step();
        bus.enable = 1'b0;
        active = 1'b0;
        step();
        chk("edge_no_valid", bus.valid, 0);
        chk("edge_hold", bus.value, 8'hFF);
        repeat (20) step();
        start(4);
        repeat (4 * WC + 10) step();
        #1 reset_n = 1'b0;
        #1;
        chk("async_value", bus.value, 8'h80);
        chk("async_valid", bus.valid, 0);
        chk("async_mclk", bus.M_CLK, 0);
        chk("async_running", bus.running, 0);
        active = 1'b0;
        exp_val = 8'h80;
        repeat (5) step();
        reset_n = 1'b1;
        start(1);
        repeat (5 * WC) step();
        chk("restart_ff", bus.value, 8'hFF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
